// File: rtl/hw_acc_cm_req_arbiter.sv
// Context-read request arbiter: round-robin over four clients, allocates a free
// request tag per grant, records tag->QPN and emits one combined tagged request.
module hw_acc_cm_req_arbiter #(
  parameter int HEAD_WIDTH      = 128,
  parameter int QPN_WIDTH       = 24,
  parameter int REQ_TAG_NUM     = 32,
  parameter int REQ_TAG_NUM_LOG = 5,
  parameter int TAG_FIELD_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [3:0]                            chnl_req_valid,
  input  logic [4*HEAD_WIDTH-1:0]               chnl_req_head,
  output logic [3:0]                            chnl_req_ready,
  output logic                                  cxt_req_valid,
  output logic [HEAD_WIDTH+TAG_FIELD_WIDTH-1:0] cxt_req_head,
  input  logic                                  cxt_req_ready,
  output logic                                  tag_qpn_mapping_table_wr_en,
  output logic [TAG_FIELD_WIDTH-1:0]            tag_qpn_mapping_table_addr,
  output logic [QPN_WIDTH-1:0]                  tag_qpn_mapping_table_din,
  input  logic                                  tag_release_valid,
  input  logic [REQ_TAG_NUM_LOG-1:0]            tag_release_tag,
  output logic [REQ_TAG_NUM_LOG:0]              tags_in_flight
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 rr_ptr_q, rr_ptr_d;
  logic [REQ_TAG_NUM-1:0]     tag_map_q, tag_map_d;
  logic [REQ_TAG_NUM_LOG:0]   inflight_q, inflight_d;
  logic [HEAD_WIDTH-1:0]      head_q;
  logic [1:0]                 grant_q;
  logic [REQ_TAG_NUM_LOG-1:0] tag_q;

  logic                       grant_found;
  logic [1:0]                 grant_ch;
  logic [REQ_TAG_NUM_LOG-1:0] free_tag;
  logic                       any_free;
  logic                       accept;
  logic                       release_hit;
  logic [HEAD_WIDTH-1:0]      sel_head;

  // Lowest valid offset from rr_ptr wins; descending scan leaves that one last.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (chnl_req_valid[rr_ptr_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_ch    = rr_ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    free_tag = '0;
    for (int i = REQ_TAG_NUM - 1; i >= 0; i--) begin
      if (!tag_map_q[i]) free_tag = REQ_TAG_NUM_LOG'(i);
    end
  end

  assign any_free    = ~&tag_map_q;
  assign sel_head    = chnl_req_head[grant_ch*HEAD_WIDTH +: HEAD_WIDTH];
  assign accept      = (state_q == IDLE) && grant_found && any_free && !rst;
  // Allocation looks at the pre-release map, so a returned tag is never reissued the same cycle.
  assign release_hit = tag_release_valid && tag_map_q[tag_release_tag];

  always_comb begin
    state_d                     = state_q;
    rr_ptr_d                    = rr_ptr_q;
    tag_map_d                   = tag_map_q;
    inflight_d                  = inflight_q;
    chnl_req_ready              = 4'b0000;
    tag_qpn_mapping_table_wr_en = 1'b0;
    tag_qpn_mapping_table_addr  = '0;
    tag_qpn_mapping_table_din   = '0;
    cxt_req_valid               = 1'b0;
    cxt_req_head                = '0;

    if (release_hit) tag_map_d[tag_release_tag] = 1'b0;
    if (accept)      tag_map_d[free_tag]        = 1'b1;
    inflight_d = inflight_q + (REQ_TAG_NUM_LOG+1)'(accept)
                            - (REQ_TAG_NUM_LOG+1)'(release_hit);

    case (state_q)
      IDLE: begin
        if (accept) begin
          chnl_req_ready              = 4'b0001 << grant_ch;
          tag_qpn_mapping_table_wr_en = 1'b1;
          tag_qpn_mapping_table_addr  = TAG_FIELD_WIDTH'(free_tag);
          tag_qpn_mapping_table_din   = sel_head[QPN_WIDTH-1:0];
          state_d                     = SEND;
        end
      end
      SEND: begin
        cxt_req_valid = 1'b1;
        cxt_req_head  = {head_q, TAG_FIELD_WIDTH'({grant_q, tag_q})};
        if (cxt_req_ready) begin
          rr_ptr_d = grant_q + 2'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 2'd0;
      tag_map_q  <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      tag_map_q  <= tag_map_d;
      inflight_q <= inflight_d;
    end
  end

  // Payload registers carry no reset; they are only observed while in SEND.
  always_ff @(posedge clk) begin
    if (accept) begin
      head_q  <= sel_head;
      grant_q <= grant_ch;
      tag_q   <= free_tag;
    end
  end

  assign tags_in_flight = inflight_q;

endmodule

// File: tb/tb_hw_acc_cm_req_arbiter.sv
// Randomized bench for hw_acc_cm_req_arbiter against a queue/array-level reference model.
module tb_hw_acc_cm_req_arbiter;

  localparam int HW = 128;
  localparam int QW = 24;
  localparam int TN = 32;
  localparam int TL = 5;
  localparam int TF = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        chnl_req_valid;
  logic [4*HW-1:0]   chnl_req_head;
  logic [3:0]        chnl_req_ready;
  logic              cxt_req_valid;
  logic [HW+TF-1:0]  cxt_req_head;
  logic              cxt_req_ready;
  logic              wr_en;
  logic [TF-1:0]     wr_addr;
  logic [QW-1:0]     wr_din;
  logic              rel_valid;
  logic [TL-1:0]     rel_tag;
  logic [TL:0]       tags_in_flight;

  always #5 clk = ~clk;

  hw_acc_cm_req_arbiter #(
    .HEAD_WIDTH(HW), .QPN_WIDTH(QW), .REQ_TAG_NUM(TN),
    .REQ_TAG_NUM_LOG(TL), .TAG_FIELD_WIDTH(TF)
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .chnl_req_valid              (chnl_req_valid),
    .chnl_req_head               (chnl_req_head),
    .chnl_req_ready              (chnl_req_ready),
    .cxt_req_valid               (cxt_req_valid),
    .cxt_req_head                (cxt_req_head),
    .cxt_req_ready               (cxt_req_ready),
    .tag_qpn_mapping_table_wr_en (wr_en),
    .tag_qpn_mapping_table_addr  (wr_addr),
    .tag_qpn_mapping_table_din   (wr_din),
    .tag_release_valid           (rel_valid),
    .tag_release_tag             (rel_tag),
    .tags_in_flight              (tags_in_flight)
  );

  // Reference model state
  bit            used[TN];
  bit            pend;
  logic [HW-1:0] p_head;
  int            p_ch, p_tag, rr;
  int            n_vec, n_err;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] rnd_head();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rnd_heads();
    for (int c = 0; c < 4; c++) chnl_req_head[c*HW +: HW] = rnd_head();
  endtask

  // Inputs are set at the falling edge; check mid-cycle, advance the model, then move on.
  task automatic step();
    #1;
    if (rst) begin
      for (int i = 0; i < TN; i++) used[i] = 1'b0;
      pend = 1'b0;
      rr   = 0;
    end else begin
      int cnt;
      int g;
      int t;
      logic [HW-1:0] gh;
      logic [TF-1:0] tf;
      cnt = 0;
      g   = -1;
      t   = -1;
      for (int i = 0; i < TN; i++) cnt += used[i];
      check_eq("tags_in_flight", tags_in_flight, cnt);
      if (pend) begin
        tf = TF'(p_ch * TN + p_tag);
        check_eq("send_valid", cxt_req_valid, 1);
        check_eq("send_head", cxt_req_head, {p_head, tf});
        check_eq("send_ready_n", chnl_req_ready, 0);
        check_eq("send_wr_en", wr_en, 0);
        if (cxt_req_ready) begin
          pend = 1'b0;
          rr   = (p_ch + 1) % 4;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (rr + k) % 4;
          if (g < 0 && chnl_req_valid[c]) g = c;
        end
        for (int i = 0; i < TN; i++) if (t < 0 && !used[i]) t = i;
        check_eq("idle_valid", cxt_req_valid, 0);
        if (g >= 0 && t >= 0) begin
          gh = chnl_req_head[g*HW +: HW];
          check_eq("grant_ready", chnl_req_ready, 4'b0001 << g);
          check_eq("grant_wr_en", wr_en, 1);
          check_eq("grant_addr", wr_addr, t);
          check_eq("grant_din", wr_din, gh[QW-1:0]);
        end else begin
          check_eq("nogrant_ready", chnl_req_ready, 0);
          check_eq("nogrant_wr_en", wr_en, 0);
        end
      end
      if (rel_valid && used[rel_tag]) used[rel_tag] = 1'b0;
      if (g >= 0 && t >= 0) begin
        used[t] = 1'b1;
        pend    = 1'b1;
        p_head  = chnl_req_head[g*HW +: HW];
        p_ch    = g;
        p_tag   = t;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; chnl_req_valid = '0; chnl_req_head = '0; cxt_req_ready = 1'b0;
    rel_valid = 1'b0; rel_tag = '0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single ch2 request carrying QPN 0x1234
    chnl_req_head[2*HW +: HW] = {104'h0, 24'h001234};
    chnl_req_valid = 4'b0100; cxt_req_ready = 1'b1;
    step();
    chnl_req_valid = 4'b0000;
    repeat (3) step();

    // All clients requesting with downstream always ready
    chnl_req_valid = 4'b1111;
    repeat (12) begin rnd_heads(); step(); end

    // Downstream stall while a request is pending
    cxt_req_ready = 1'b0;
    repeat (6) step();
    cxt_req_ready = 1'b1;
    repeat (2) step();

    // Tag exhaustion, then single releases racing grant attempts
    repeat (70) begin rnd_heads(); step(); end
    rel_valid = 1'b1; rel_tag = 5'd7;
    step();
    rel_valid = 1'b0;
    repeat (4) step();
    rel_valid = 1'b1; rel_tag = 5'd3;
    step();
    rel_valid = 1'b0;
    repeat (4) step();
    rel_valid = 1'b1; rel_tag = 5'd3;
    step();
    rel_valid = 1'b0;
    step();

    // Reset while a request is pending
    chnl_req_valid = 4'b0000;
    repeat (2) step();
    cxt_req_ready = 1'b0;
    chnl_req_valid = 4'b1000;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0; chnl_req_valid = 4'b1111; cxt_req_ready = 1'b1;
    repeat (3) step();

    // Randomized traffic with occasional resets
    repeat (1500) begin
      rst            = ($urandom_range(0, 199) == 0);
      chnl_req_valid = 4'($urandom);
      cxt_req_ready  = ($urandom_range(0, 3) != 0);
      rel_valid      = ($urandom_range(0, 2) != 0);
      rel_tag        = 5'($urandom);
      rnd_heads();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
